// File: rtl/uart_rx_fifo.sv
// UART receiver with run-time frame format and 3-sample majority vote, feeding a first-word
// fall-through FIFO; a word is written one clock after its last stop-bit decision, dropped (overrun) when full.
module uart_rx_fifo #(
    parameter int DIV_W       = 32,
    parameter int FIFO_DEPTH  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [DIV_W-1:0]            clk_div,
    input  logic [1:0]                  cfg_data_bits,
    input  logic [1:0]                  cfg_parity,
    input  logic                        cfg_stop2,
    input  logic                        rx,
    output logic                        rd_valid,
    input  logic                        rd_ready,
    output logic [7:0]                  rd_data,
    output logic [1:0]                  rd_err,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    output logic                        frame_err,
    output logic                        parity_err,
    output logic                        overrun,
    input  logic                        err_clr,
    output logic                        busy
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP1, S_STOP2, S_PUSH, S_BREAK
    } state_t;

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   rx_prev_q, rx_prev_d;
    logic                   rx_s, rx_fall;

    state_t           state_q;
    logic [DIV_W-1:0] cnt_q, div_q, half;
    logic [2:0]       last_idx_q, bit_idx_q;
    logic             par_en_q, par_odd_q, stop2_q;
    logic [7:0]       data_q;
    logic [1:0]       samp_q;
    logic             perr_q, ferr_q;
    logic             in_bit, at_s0, at_s1, at_dec, at_end, maj;

    logic [9:0]    mem_q [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          push, pop, full, wr_en, drop;
    logic          frame_err_q, frame_err_d, parity_err_q, parity_err_d, overrun_q, overrun_d;
    logic [9:0]    head;

    always_comb begin
        sync_d    = {sync_q[SYNC_STAGES-2:0], rx};
        rx_prev_d = rx_s;
    end

    assign rx_s    = sync_q[SYNC_STAGES-1];
    assign rx_fall = rx_prev_q & ~rx_s;

    assign half   = div_q >> 1;
    assign in_bit = (state_q == S_START) || (state_q == S_DATA) || (state_q == S_PARITY) ||
                    (state_q == S_STOP1) || (state_q == S_STOP2);
    assign at_s0  = (cnt_q == half - DIV_W'(1));
    assign at_s1  = (cnt_q == half);
    assign at_dec = (cnt_q == half + DIV_W'(1));
    assign at_end = (cnt_q == div_q - DIV_W'(1));
    // Third vote is the live synchronised sample taken on the decision cycle.
    assign maj    = (samp_q[0] & samp_q[1]) | (samp_q[0] & rx_s) | (samp_q[1] & rx_s);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            div_q      <= DIV_W'(4);
            last_idx_q <= 3'd7;
            par_en_q   <= 1'b0;
            par_odd_q  <= 1'b0;
            stop2_q    <= 1'b0;
            bit_idx_q  <= '0;
            data_q     <= '0;
            samp_q     <= '0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
        end else begin
            if (in_bit) begin
                cnt_q <= at_end ? '0 : cnt_q + DIV_W'(1);
                if (at_s0) samp_q[0] <= rx_s;
                if (at_s1) samp_q[1] <= rx_s;
            end
            case (state_q)
                S_IDLE: begin
                    // An illegal divider never leaves IDLE, so the FSM cannot hang on it.
                    if (rx_fall && (clk_div >= DIV_W'(4))) begin
                        state_q    <= S_START;
                        cnt_q      <= '0;
                        div_q      <= clk_div;
                        last_idx_q <= {1'b1, cfg_data_bits};
                        par_en_q   <= (cfg_parity == 2'b01) || (cfg_parity == 2'b10);
                        par_odd_q  <= (cfg_parity == 2'b10);
                        stop2_q    <= cfg_stop2;
                        bit_idx_q  <= '0;
                        data_q     <= '0;
                        perr_q     <= 1'b0;
                        ferr_q     <= 1'b0;
                    end
                end
                S_START: begin
                    if (at_dec && maj) state_q <= S_IDLE;
                    else if (at_end)   state_q <= S_DATA;
                end
                S_DATA: begin
                    if (at_dec) data_q[bit_idx_q] <= maj;
                    if (at_end) begin
                        if (bit_idx_q == last_idx_q) state_q <= par_en_q ? S_PARITY : S_STOP1;
                        else                         bit_idx_q <= bit_idx_q + 3'd1;
                    end
                end
                S_PARITY: begin
                    if (at_dec) perr_q <= (^data_q) ^ maj ^ par_odd_q;
                    if (at_end) state_q <= S_STOP1;
                end
                S_STOP1: begin
                    if (at_dec) begin
                        ferr_q <= ferr_q | ~maj;
                        if (!stop2_q) state_q <= S_PUSH;
                    end else if (at_end) begin
                        state_q <= S_STOP2;
                    end
                end
                S_STOP2: begin
                    if (at_dec) begin
                        ferr_q  <= ferr_q | ~maj;
                        state_q <= S_PUSH;
                    end
                end
                S_PUSH:  state_q <= ferr_q ? S_BREAK : S_IDLE;
                S_BREAK: if (rx_s) state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign push  = (state_q == S_PUSH);
    assign pop   = rd_ready && (count_q != '0);
    assign full  = (count_q == CW'(FIFO_DEPTH));
    assign wr_en = push && (!full || pop);
    assign drop  = push && full && !pop;

    always_comb begin
        wr_ptr_d = wr_en ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
        count_d  = count_q;
        if (wr_en && !pop)      count_d = count_q + CW'(1);
        else if (!wr_en && pop) count_d = count_q - CW'(1);
        // A new error outranks a simultaneous clear.
        frame_err_d  = (push & ferr_q) | (frame_err_q & ~err_clr);
        parity_err_d = (push & perr_q) | (parity_err_q & ~err_clr);
        overrun_d    = drop | (overrun_q & ~err_clr);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q       <= '1;
            rx_prev_q    <= 1'b1;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            sync_q       <= sync_d;
            rx_prev_q    <= rx_prev_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            frame_err_q  <= frame_err_d;
            parity_err_q <= parity_err_d;
            overrun_q    <= overrun_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= {perr_q, ferr_q, data_q};
    end

    assign head       = mem_q[rd_ptr_q];
    assign rd_valid   = (count_q != '0);
    assign rd_data    = rd_valid ? head[7:0] : 8'h00;
    assign rd_err     = rd_valid ? head[9:8] : 2'b00;
    assign fifo_count = count_q;
    assign frame_err  = frame_err_q;
    assign parity_err = parity_err_q;
    assign overrun    = overrun_q;
    assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: frame-format vector table, hand-written timing/corner sequences,
// and randomized frame bursts scored against a queue model of the receive FIFO.
module tb_uart_rx_fifo;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] clk_div = 32'd16;
    logic [1:0]  cfg_data_bits = 2'b11;
    logic [1:0]  cfg_parity = 2'b00;
    logic        cfg_stop2 = 1'b0;
    logic        rx = 1'b1;
    logic        rd_ready = 1'b0;
    logic        err_clr = 1'b0;
    logic        rd_valid, frame_err, parity_err, overrun, busy;
    logic [7:0]  rd_data;
    logic [1:0]  rd_err;
    logic [$clog2(DEPTH):0] fifo_count;

    int n_cmp = 0;
    int n_bad = 0;

    uart_rx_fifo #(.DIV_W(32), .FIFO_DEPTH(DEPTH), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .clk_div(clk_div), .cfg_data_bits(cfg_data_bits),
        .cfg_parity(cfg_parity), .cfg_stop2(cfg_stop2), .rx(rx), .rd_valid(rd_valid),
        .rd_ready(rd_ready), .rd_data(rd_data), .rd_err(rd_err), .fifo_count(fifo_count),
        .frame_err(frame_err), .parity_err(parity_err), .overrun(overrun),
        .err_clr(err_clr), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Returns 1 time unit after the n-th rising edge.
    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pop_expect(input string tag, input logic [9:0] w);
        check({tag, "_vld"}, 32'(rd_valid), 32'd1);
        check({tag, "_dat"}, 32'(rd_data), 32'(w[7:0]));
        check({tag, "_err"}, 32'(rd_err), 32'(w[9:8]));
        rd_ready = 1'b1;
        wait_clk(1);
        rd_ready = 1'b0;
    endtask

    task automatic pulse_clr();
        err_clr = 1'b1;
        wait_clk(1);
        err_clr = 1'b0;
    endtask

    // par: 0 none, 1 even, 2 odd, 3 none. glitch_bit indexes the frame (0 = start bit).
    task automatic send_frame(input logic [7:0] d, input int nb, input int par, input bit flip,
                              input bit two, input bit s1, input bit s2,
                              input int glitch_bit, input bit leave_low);
        bit   bits[$];
        logic p;
        int   div;
        div           = int'(clk_div);
        cfg_data_bits = 2'(nb - 5);
        cfg_parity    = 2'(par);
        cfg_stop2     = two;
        p             = 1'b0;
        bits.push_back(1'b0);
        for (int i = 0; i < nb; i++) begin
            bits.push_back(d[i]);
            p = p ^ d[i];
        end
        if (par == 1) bits.push_back(p ^ flip);
        if (par == 2) bits.push_back(~p ^ flip);
        bits.push_back(s1);
        if (two) bits.push_back(s2);
        for (int i = 0; i < bits.size(); i++) begin
            rx = bits[i];
            if (i == glitch_bit) begin
                wait_clk(div / 2 + 1);
                rx = ~bits[i];
                wait_clk(1);
                rx = bits[i];
                wait_clk(div - div / 2 - 2);
            end else begin
                wait_clk(div);
            end
        end
        if (leave_low) begin
            rx = 1'b0;
        end else begin
            rx = 1'b1;
            wait_clk(2 * div);
        end
    endtask

    // 8N1 at 16 clocks/bit; returns during the cycle right after the stop-bit decision.
    task automatic send_8n1_to_push(input logic [7:0] d, input bit scramble);
        clk_div = 32'd16; cfg_data_bits = 2'b11; cfg_parity = 2'b00; cfg_stop2 = 1'b0;
        rx = 1'b0;
        wait_clk(16);
        if (scramble) begin
            clk_div = 32'd8; cfg_data_bits = 2'b00; cfg_parity = 2'b10; cfg_stop2 = 1'b1;
        end
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            wait_clk(16);
        end
        rx = 1'b1;
        wait_clk(13);
    endtask

    typedef struct {
        logic [7:0] d;
        int         nb;
        int         par;
        bit         flip;
        bit         two;
        bit         s1;
        bit         s2;
        logic [7:0] exp_d;
        logic [1:0] exp_e;
    } vec_t;

    vec_t tbl[7];

    logic [9:0] mq[$];
    bit         exp_pe, exp_fe, exp_ovr;

    initial begin
        tbl[0] = '{8'hA5, 8, 0, 1'b0, 1'b0, 1'b1, 1'b1, 8'hA5, 2'b00};
        tbl[1] = '{8'h35, 7, 1, 1'b1, 1'b0, 1'b1, 1'b1, 8'h35, 2'b10};
        tbl[2] = '{8'h1B, 5, 2, 1'b0, 1'b1, 1'b1, 1'b0, 8'h1B, 2'b01};
        tbl[3] = '{8'hFF, 6, 0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h3F, 2'b00};
        tbl[4] = '{8'h5A, 8, 2, 1'b0, 1'b1, 1'b1, 1'b1, 8'h5A, 2'b00};
        tbl[5] = '{8'h00, 8, 1, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 2'b11};
        tbl[6] = '{8'hC4, 7, 3, 1'b0, 1'b0, 1'b1, 1'b1, 8'h44, 2'b00};

        // Reset state
        wait_clk(3);
        check("rst_vld", 32'(rd_valid), 32'd0);
        check("rst_cnt", 32'(fifo_count), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_flags", 32'({frame_err, parity_err, overrun}), 32'd0);
        check("rst_dat", 32'({rd_data, rd_err}), 32'd0);
        rst = 1'b0;
        wait_clk(4);

        // Push latency for 8N1 0xA5, with config changed mid-frame
        send_8n1_to_push(8'hA5, 1'b1);
        check("lat_busy", 32'(busy), 32'd1);
        check("lat_pre_vld", 32'(rd_valid), 32'd0);
        wait_clk(1);
        check("lat_post_vld", 32'(rd_valid), 32'd1);
        check("lat_cnt", 32'(fifo_count), 32'd1);
        wait_clk(34);
        check("lat_idle", 32'(busy), 32'd0);
        pop_expect("lat", {2'b00, 8'hA5});

        // Frame-format vector table
        clk_div = 32'd16;
        for (int v = 0; v < 7; v++) begin
            send_frame(tbl[v].d, tbl[v].nb, tbl[v].par, tbl[v].flip, tbl[v].two,
                       tbl[v].s1, tbl[v].s2, -1, 1'b0);
            check($sformatf("vec%0d_cnt", v), 32'(fifo_count), 32'd1);
            pop_expect($sformatf("vec%0d", v), {tbl[v].exp_e, tbl[v].exp_d});
            check($sformatf("vec%0d_perr", v), 32'(parity_err), 32'(tbl[v].exp_e[1]));
            check($sformatf("vec%0d_ferr", v), 32'(frame_err), 32'(tbl[v].exp_e[0]));
            pulse_clr();
            check($sformatf("vec%0d_clr", v), 32'({frame_err, parity_err, overrun}), 32'd0);
        end

        // 5O2 with bad second stop then a long break
        send_frame(8'h0B, 5, 2, 1'b0, 1'b1, 1'b1, 1'b0, -1, 1'b1);
        wait_clk(20 * 16);
        check("brk_busy", 32'(busy), 32'd1);
        check("brk_cnt", 32'(fifo_count), 32'd1);
        check("brk_ferr", 32'(frame_err), 32'd1);
        wait_clk(20 * 16);
        rx = 1'b1;
        wait_clk(32);
        check("brk_end_busy", 32'(busy), 32'd0);
        check("brk_end_cnt", 32'(fifo_count), 32'd1);
        pop_expect("brk", {2'b01, 8'h0B});
        check("brk_empty", 32'(rd_valid), 32'd0);
        pulse_clr();

        // False start then glitched data bit
        rx = 1'b0;
        wait_clk(6);
        rx = 1'b1;
        wait_clk(48);
        check("fs_busy", 32'(busy), 32'd0);
        check("fs_vld", 32'(rd_valid), 32'd0);
        send_frame(8'h3C, 8, 0, 1'b0, 1'b0, 1'b1, 1'b1, 4, 1'b0);
        send_frame(8'hC3, 8, 0, 1'b0, 1'b0, 1'b1, 1'b1, 0, 1'b0);
        check("gl_cnt", 32'(fifo_count), 32'd2);
        pop_expect("gl0", {2'b00, 8'h3C});
        pop_expect("gl1", {2'b00, 8'hC3});

        // Overrun at full, then pop coinciding with a push at full
        for (int i = 1; i <= 5; i++) send_frame(8'(i * 17), 8, 0, 1'b0, 1'b0, 1'b1, 1'b1, -1, 1'b0);
        check("ovr_cnt", 32'(fifo_count), 32'd4);
        check("ovr_flag", 32'(overrun), 32'd1);
        for (int i = 1; i <= 4; i++) pop_expect($sformatf("ovr_w%0d", i), {2'b00, 8'(i * 17)});
        check("ovr_empty", 32'(rd_valid), 32'd0);
        pulse_clr();
        for (int i = 1; i <= 4; i++) send_frame(8'(8'h60 + i), 8, 0, 1'b0, 1'b0, 1'b1, 1'b1, -1, 1'b0);
        check("pp_full", 32'(fifo_count), 32'd4);
        send_8n1_to_push(8'h66, 1'b0);
        rd_ready = 1'b1;
        wait_clk(1);
        rd_ready = 1'b0;
        wait_clk(34);
        check("pp_cnt", 32'(fifo_count), 32'd4);
        check("pp_ovr", 32'(overrun), 32'd0);
        pop_expect("pp_w2", {2'b00, 8'h62});
        pop_expect("pp_w3", {2'b00, 8'h63});
        pop_expect("pp_w4", {2'b00, 8'h64});
        pop_expect("pp_w6", {2'b00, 8'h66});

        // Reset mid-DATA with two words queued
        send_frame(8'h12, 8, 0, 1'b0, 1'b0, 1'b1, 1'b1, -1, 1'b0);
        send_frame(8'h34, 8, 0, 1'b0, 1'b0, 1'b1, 1'b1, -1, 1'b0);
        rx = 1'b0;
        wait_clk(16);
        rx = 1'b1;
        wait_clk(48);
        check("mrst_busy_pre", 32'(busy), 32'd1);
        rst = 1'b1;
        wait_clk(1);
        check("mrst_vld", 32'(rd_valid), 32'd0);
        check("mrst_cnt", 32'(fifo_count), 32'd0);
        check("mrst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        wait_clk(32);
        send_frame(8'h96, 8, 0, 1'b0, 1'b0, 1'b1, 1'b1, -1, 1'b0);
        check("mrst_next_cnt", 32'(fifo_count), 32'd1);
        pop_expect("mrst_next", {2'b00, 8'h96});

        // Randomized bursts against a queue model
        for (int it = 0; it < 10; it++) begin
            int nfr, nb, par;
            bit two;
            mq.delete();
            exp_pe = 1'b0; exp_fe = 1'b0; exp_ovr = 1'b0;
            nfr     = $urandom_range(1, 5);
            clk_div = 32'($urandom_range(6, 24));
            nb      = $urandom_range(5, 8);
            par     = $urandom_range(0, 3);
            two     = 1'($urandom_range(0, 1));
            for (int f = 0; f < nfr; f++) begin
                logic [7:0] d, dm;
                bit flip, s1, s2, pe, fe;
                d  = 8'($urandom);
                dm = d & 8'((1 << nb) - 1);
                flip = 1'b0; s1 = 1'b1; s2 = 1'b1;
                if (mq.size() < DEPTH) begin
                    flip = ($urandom_range(0, 3) == 0);
                    s1   = ($urandom_range(0, 5) != 0);
                    s2   = ($urandom_range(0, 5) != 0);
                end
                pe = flip && (par == 1 || par == 2);
                fe = !s1 || (two && !s2);
                send_frame(d, nb, par, flip, two, s1, s2, -1, 1'b0);
                if (mq.size() < DEPTH) begin
                    mq.push_back({pe, fe, dm});
                    exp_pe = exp_pe | pe;
                    exp_fe = exp_fe | fe;
                end else begin
                    exp_ovr = 1'b1;
                end
            end
            check($sformatf("rnd%0d_cnt", it), 32'(fifo_count), 32'(mq.size()));
            check($sformatf("rnd%0d_flags", it), 32'({frame_err, parity_err, overrun}),
                  32'({exp_fe, exp_pe, exp_ovr}));
            while (mq.size() > 0) pop_expect($sformatf("rnd%0d", it), mq.pop_front());
            check($sformatf("rnd%0d_empty", it), 32'(rd_valid), 32'd0);
            pulse_clr();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
